xbar_core_l2: RTL and testbench

Parametrised N-port request crossbar between core-side memory clients (port 0 is always the HTIF host port) and the single L2/memory request channel. The block replaces the fixed two-input combinational mux. It arbitrates among NPORTS requesters and registers the winner in a one-entry output buffer. It prefixes each tag with a port ID, caps outstanding requests per port, and demultiplexes responses back to the issuing port by tag ID.

---
 rtl/xbar_core_l2.sv | 179 +++++++++++++++++
 tb/tb_xbar_core_l2.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_core_l2.sv
// N-port request crossbar onto a single L2 request channel through a one-entry output buffer.
// Define XBAR_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (port 0 first).
`timescale 1ns/1ps
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_L2TAG_BITS
`define MEM_L2TAG_BITS 7
`endif

module xbar_core_l2 #(
  parameter int NPORTS          = 2,
  parameter int ID_BITS         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [NPORTS-1:0]                  port_req_val_i,
  output logic [NPORTS-1:0]                  port_req_rdy_o,
  input  logic [NPORTS-1:0]                  port_req_rw_i,
  input  logic [NPORTS*`MEM_ADDR_BITS-1:0]   port_req_addr_i,
  input  logic [NPORTS*`MEM_DATA_BITS-1:0]   port_req_data_i,
  input  logic [NPORTS*`MEM_TAG_BITS-1:0]    port_req_tag_i,
  output logic [NPORTS-1:0]                  port_resp_val_o,
  output logic [NPORTS-1:0]                  port_resp_nack_o,
  output logic [`MEM_DATA_BITS-1:0]          port_resp_data_o,
  output logic [`MEM_TAG_BITS-1:0]           port_resp_tag_o,
  output logic                               mem_req_val_o,
  input  logic                               mem_req_rdy_i,
  output logic [1:0]                         mem_req_rw_o,
  output logic [`MEM_ADDR_BITS-1:0]          mem_req_addr_o,
  output logic [`MEM_DATA_BITS-1:0]          mem_req_data_o,
  output logic [`MEM_L2TAG_BITS-1:0]         mem_req_tag_o,
  input  logic                               mem_resp_val_i,
  input  logic                               mem_resp_nack_i,
  input  logic [`MEM_DATA_BITS-1:0]          mem_resp_data_i,
  input  logic [`MEM_L2TAG_BITS-1:0]         mem_resp_tag_i
);
  localparam int AW = `MEM_ADDR_BITS;
  localparam int DW = `MEM_DATA_BITS;
  localparam int TW = `MEM_TAG_BITS;
  localparam int LW = `MEM_L2TAG_BITS;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]      cnt_q [NPORTS];
  logic [CW-1:0]      cnt_d [NPORTS];
  logic               buf_val_q, buf_val_d;
  logic [1:0]         rw_q, rw_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      data_q, data_d;
  logic [LW-1:0]      tag_q, tag_d;
  logic [NPORTS-1:0]  elig, grant, dec;
  logic [ID_BITS-1:0] gnt_idx, resp_id;
  logic               gnt_any, buf_free, accept, resp_any;

  assign buf_free = ~buf_val_q | mem_req_rdy_i;
  assign resp_id  = mem_resp_tag_i[LW-1 -: ID_BITS];
  assign resp_any = mem_resp_val_i | mem_resp_nack_i;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NPORTS; i++) elig[i] = port_req_val_i[i] && (cnt_q[i] < CNT_MAX);
  end

`ifdef XBAR_RR_ARB_EN
  logic [ID_BITS-1:0] ptr_q, ptr_d;
  int                 rr_j;

  // Search starts at the pointer and wraps; first eligible port wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_j    = 0;
    for (int k = 0; k < NPORTS; k++) begin
      rr_j = int'(ptr_q) + k;
      if (rr_j >= NPORTS) rr_j = rr_j - NPORTS;
      if (!gnt_any && elig[rr_j]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_BITS'(rr_j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (gnt_idx == ID_BITS'(NPORTS - 1)) ? '0 : gnt_idx + ID_BITS'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_BITS'(i);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (gnt_any && buf_free && !reset_i) grant[gnt_idx] = 1'b1;
  end

  assign accept         = |grant;
  assign port_req_rdy_o = grant;

  // A reload in the same cycle as a drain keeps the buffer full.
  always_comb begin
    buf_val_d = buf_val_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tag_d     = tag_q;
    if (accept) begin
      buf_val_d = 1'b1;
      rw_d      = {gnt_idx == '0, port_req_rw_i[gnt_idx]};
      addr_d    = port_req_addr_i[int'(gnt_idx)*AW +: AW];
      data_d    = port_req_data_i[int'(gnt_idx)*DW +: DW];
      tag_d     = {gnt_idx, port_req_tag_i[int'(gnt_idx)*TW +: TW]};
    end else if (mem_req_rdy_i) begin
      buf_val_d = 1'b0;
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign dec[g]              = resp_any && (resp_id == ID_BITS'(g));
    assign port_resp_val_o[g]  = mem_resp_val_i && (resp_id == ID_BITS'(g));
    assign port_resp_nack_o[g] = mem_resp_nack_i && (resp_id == ID_BITS'(g));
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !dec[i])                        cnt_d[i] = cnt_q[i] + CW'(1);
      else if (!grant[i] && dec[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_val_q <= 1'b0;
      rw_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      for (int i = 0; i < NPORTS; i++) cnt_q[i] <= '0;
    end else begin
      buf_val_q <= buf_val_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      for (int i = 0; i < NPORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign mem_req_val_o    = buf_val_q;
  assign mem_req_rw_o     = rw_q;
  assign mem_req_addr_o   = addr_q;
  assign mem_req_data_o   = data_q;
  assign mem_req_tag_o    = tag_q;
  assign port_resp_data_o = mem_resp_data_i;
  assign port_resp_tag_o  = mem_resp_tag_i[TW-1:0];

endmodule

// File: tb/tb_xbar_core_l2.sv
// Self-checking bench for xbar_core_l2: behavioural model + request scoreboard, response table.
`timescale 1ns/1ps
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_L2TAG_BITS
`define MEM_L2TAG_BITS 7
`endif

module tb_xbar_core_l2;
  localparam int NP = 2, IDB = 2, MO = 4;
  localparam int AW = `MEM_ADDR_BITS, DW = `MEM_DATA_BITS, TW = `MEM_TAG_BITS, LW = `MEM_L2TAG_BITS;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [NP-1:0]     port_req_val_i, port_req_rdy_o, port_req_rw_i;
  logic [NP*AW-1:0]  port_req_addr_i;
  logic [NP*DW-1:0]  port_req_data_i;
  logic [NP*TW-1:0]  port_req_tag_i;
  logic [NP-1:0]     port_resp_val_o, port_resp_nack_o;
  logic [DW-1:0]     port_resp_data_o;
  logic [TW-1:0]     port_resp_tag_o;
  logic              mem_req_val_o, mem_req_rdy_i;
  logic [1:0]        mem_req_rw_o;
  logic [AW-1:0]     mem_req_addr_o;
  logic [DW-1:0]     mem_req_data_o;
  logic [LW-1:0]     mem_req_tag_o;
  logic              mem_resp_val_i, mem_resp_nack_i;
  logic [DW-1:0]     mem_resp_data_i;
  logic [LW-1:0]     mem_resp_tag_i;

  xbar_core_l2 #(.NPORTS(NP), .ID_BITS(IDB), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .port_req_val_i(port_req_val_i), .port_req_rdy_o(port_req_rdy_o), .port_req_rw_i(port_req_rw_i),
    .port_req_addr_i(port_req_addr_i), .port_req_data_i(port_req_data_i), .port_req_tag_i(port_req_tag_i),
    .port_resp_val_o(port_resp_val_o), .port_resp_nack_o(port_resp_nack_o),
    .port_resp_data_o(port_resp_data_o), .port_resp_tag_o(port_resp_tag_o),
    .mem_req_val_o(mem_req_val_o), .mem_req_rdy_i(mem_req_rdy_i), .mem_req_rw_o(mem_req_rw_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_resp_val_i(mem_resp_val_i), .mem_resp_nack_i(mem_resp_nack_i),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_tag_i(mem_resp_tag_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]    rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [LW-1:0] tag;
  } req_t;

  typedef struct {
    logic          v;
    logic          n;
    logic [LW-1:0] tag;
    logic [NP-1:0] e_val;
    logic [NP-1:0] e_nack;
    logic [NP-1:0] e_rdy;
    logic [TW-1:0] e_tag;
  } rv_t;

  req_t sb_q[$];
  int   n_pass = 0, n_total = 0;
  int   mcnt[NP];
  int   mp;
  bit   mbuf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NP-1:0] model_grant();
    logic [NP-1:0] g;
    g = '0;
    if (reset_i || (mbuf && !mem_req_rdy_i)) return g;
`ifdef XBAR_RR_ARB_EN
    for (int k = 0; k < NP; k++) begin
      int j;
      j = (mp + k) % NP;
      if (port_req_val_i[j] && mcnt[j] < MO) begin g[j] = 1'b1; return g; end
    end
`else
    for (int j = 0; j < NP; j++)
      if (port_req_val_i[j] && mcnt[j] < MO) begin g[j] = 1'b1; return g; end
`endif
    return g;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NP; j++) mcnt[j] = 0;
    mp = 0;
    mbuf = 1'b0;
    sb_q.delete();
  endtask

  task automatic set_port(input int j, input logic rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [TW-1:0] t);
    port_req_rw_i[j]             = rw;
    port_req_addr_i[j*AW +: AW]  = a;
    port_req_data_i[j*DW +: DW]  = d;
    port_req_tag_i[j*TW +: TW]   = t;
  endtask

  task automatic cycle();
    logic [NP-1:0] g, ev, en;
    int id;
    bit hit;
    req_t r;
    @(negedge clk_i);
    g = model_grant();
    chk("req_rdy", port_req_rdy_o, g);
    chk("mem_req_val", mem_req_val_o, mbuf);
    if (mem_req_val_o) begin
      if (sb_q.size() == 0) chk("sb_underrun", sb_q.size(), 1);
      else begin
        chk("mem_req_rw", mem_req_rw_o, sb_q[0].rw);
        chk("mem_req_addr", mem_req_addr_o, sb_q[0].addr);
        chk("mem_req_data", mem_req_data_o, sb_q[0].data);
        chk("mem_req_tag", mem_req_tag_o, sb_q[0].tag);
        if (mem_req_rdy_i) void'(sb_q.pop_front());
      end
    end
    id = int'(mem_resp_tag_i[LW-1 -: IDB]);
    ev = '0;
    en = '0;
    if (id < NP) begin ev[id] = mem_resp_val_i; en[id] = mem_resp_nack_i; end
    hit = (mem_resp_val_i || mem_resp_nack_i) && id < NP;
    chk("resp_val", port_resp_val_o, ev);
    chk("resp_nack", port_resp_nack_o, en);
    chk("resp_tag", port_resp_tag_o, mem_resp_tag_i[TW-1:0]);
    chk("resp_data", port_resp_data_o, mem_resp_data_i);
    for (int j = 0; j < NP; j++) begin
      if (g[j]) begin
        r.rw   = {(j == 0), port_req_rw_i[j]};
        r.addr = port_req_addr_i[j*AW +: AW];
        r.data = port_req_data_i[j*DW +: DW];
        r.tag  = {IDB'(j), port_req_tag_i[j*TW +: TW]};
        sb_q.push_back(r);
      end
    end
    @(posedge clk_i);
    #1;
    for (int j = 0; j < NP; j++) begin
      if (g[j] && !(hit && id == j)) mcnt[j]++;
      else if (!g[j] && hit && id == j && mcnt[j] > 0) mcnt[j]--;
      if (g[j]) mp = (j + 1) % NP;
    end
    if (g != '0) mbuf = 1'b1;
    else if (mem_req_rdy_i) mbuf = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    port_req_val_i = '1;
    port_req_rw_i = '0; port_req_addr_i = '0; port_req_data_i = '0; port_req_tag_i = '0;
    mem_req_rdy_i = 1'b0; mem_resp_val_i = 1'b0; mem_resp_nack_i = 1'b0;
    mem_resp_data_i = '0; mem_resp_tag_i = '0;
    model_reset();
    @(negedge clk_i);
    chk("rst_mem_val", mem_req_val_o, 1'b0);
    chk("rst_req_rdy", port_req_rdy_o, '0);
    chk("rst_mem_tag", mem_req_tag_o, '0);
    chk("rst_mem_addr", mem_req_addr_o, '0);
    chk("rst_mem_rw", mem_req_rw_o, '0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    port_req_val_i = '0;
  endtask

  rv_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 7'h63, 2'b00, 2'b00, 2'b00, 5'h03};
    tbl[1] = '{1'b1, 1'b0, 7'h44, 2'b00, 2'b00, 2'b00, 5'h04};
    tbl[2] = '{1'b1, 1'b1, 7'h01, 2'b01, 2'b01, 2'b00, 5'h01};
    tbl[3] = '{1'b1, 1'b0, 7'h27, 2'b10, 2'b00, 2'b00, 5'h07};
    tbl[4] = '{1'b0, 1'b0, 7'h00, 2'b00, 2'b00, 2'b10, 5'h00};
    tbl[5] = '{1'b0, 1'b1, 7'h22, 2'b00, 2'b10, 2'b00, 5'h02};
    tbl[6] = '{1'b0, 1'b0, 7'h00, 2'b00, 2'b00, 2'b10, 5'h00};

    // single request from the host port
    do_reset();
    set_port(0, 1'b0, 'h10, 64'hA5A5_0000_1234_5678, 5'd3);
    port_req_val_i = 2'b01;
    mem_req_rdy_i = 1'b1;
    #1 chk("t1_rdy", port_req_rdy_o, 2'b01);
    cycle();
    port_req_val_i = '0;
    chk("t1_val", mem_req_val_o, 1'b1);
    chk("t1_tag", mem_req_tag_o, 7'h03);
    chk("t1_rw", mem_req_rw_o, 2'b10);
    chk("t1_addr", mem_req_addr_o, 'h10);
    cycle();

    // two contenders, arbitration order
    do_reset();
    set_port(0, 1'b1, 'h100, 64'h1111, 5'd1);
    set_port(1, 1'b0, 'h200, 64'h2222, 5'd2);
    port_req_val_i = 2'b11;
    mem_req_rdy_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef XBAR_RR_ARB_EN
      chk("arb_seq", port_req_rdy_o, (k % 2 == 0) ? 2'b01 : 2'b10);
`else
      chk("arb_seq", port_req_rdy_o, 2'b01);
`endif
      set_port(0, 1'b1, AW'(32'h100 + k), DW'($urandom), 5'd1);
      set_port(1, 1'b0, AW'(32'h200 + k), DW'($urandom), 5'd2);
      cycle();
    end
    port_req_val_i = '0;
    cycle();

    // backpressure with a full buffer
    do_reset();
    set_port(0, 1'b0, 'h3AB, 64'hDEAD_BEEF, 5'd4);
    port_req_val_i = 2'b01;
    mem_req_rdy_i = 1'b1;
    cycle();
    mem_req_rdy_i = 1'b0;
    set_port(0, 1'b1, 'h3C0, 64'hC0C0, 5'd5);
    set_port(1, 1'b1, 'h3C1, 64'hC1C1, 5'd6);
    port_req_val_i = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rdy", port_req_rdy_o, 2'b00);
      chk("bp_addr", mem_req_addr_o, 'h3AB);
      cycle();
    end
    mem_req_rdy_i = 1'b1;
    #1;
`ifdef XBAR_RR_ARB_EN
    chk("bp_refill", port_req_rdy_o, 2'b10);
`else
    chk("bp_refill", port_req_rdy_o, 2'b01);
`endif
    cycle();
    port_req_val_i = '0;
    chk("bp_next_val", mem_req_val_o, 1'b1);
    cycle();

    // outstanding cap on port 1, then response table with port 1 held valid
    do_reset();
    mem_req_rdy_i = 1'b1;
    port_req_val_i = 2'b10;
    for (int k = 0; k < 4; k++) begin
      set_port(1, k[0], AW'(32'h400 + k), DW'($urandom), TW'(k));
      cycle();
    end
    #1 chk("cap_rdy", port_req_rdy_o, 2'b00);
    mem_resp_nack_i = 1'b1;
    mem_resp_tag_i = 7'h29;
    cycle();
    mem_resp_nack_i = 1'b0;
    mem_resp_tag_i = '0;
    #1 chk("cap_release", port_req_rdy_o, 2'b10);
    cycle();
    for (int r = 0; r < 7; r++) begin
      mem_resp_val_i  = tbl[r].v;
      mem_resp_nack_i = tbl[r].n;
      mem_resp_tag_i  = tbl[r].tag;
      mem_resp_data_i = {$urandom, $urandom};
      #1;
      chk("tbl_rdy", port_req_rdy_o, tbl[r].e_rdy);
      chk("tbl_val", port_resp_val_o, tbl[r].e_val);
      chk("tbl_nack", port_resp_nack_o, tbl[r].e_nack);
      chk("tbl_tag", port_resp_tag_o, tbl[r].e_tag);
      cycle();
    end
    mem_resp_val_i = 1'b0;
    mem_resp_nack_i = 1'b0;
    port_req_val_i = '0;

    // reset while a request sits in the buffer
    do_reset();
    set_port(0, 1'b1, 'h555, 64'h5555, 5'd9);
    port_req_val_i = 2'b01;
    mem_req_rdy_i = 1'b1;
    cycle();
    port_req_val_i = '0;
    mem_req_rdy_i = 1'b0;
    @(negedge clk_i);
    chk("mid_full", mem_req_val_o, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    chk("mid_val", mem_req_val_o, 1'b0);
    chk("mid_tag", mem_req_tag_o, '0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    model_reset();
    mem_req_rdy_i = 1'b1;
    for (int k = 0; k < 3; k++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
